// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, default widths, word packing sizes
// and the inter-byte timeout default derived from clock and baud rate.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_WAIT_LOW = 2'd2
    } rx_state_e;

    localparam int UART_NBIT_DEF      = 8;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int BYTES_PER_WORD_DEF = DATA_WIDTH_DEF / UART_NBIT_DEF;
    localparam int BYTE_CNT_W         = $clog2(BYTES_PER_WORD_DEF) + 1;

    localparam int CLK_FREQ_HZ = 1_152_000;
    localparam int BAUDRATE    = 115_200;
    localparam int FRAME_BITS  = 10;

    // start + 8 data + stop bits per frame, counted in system clocks
    function automatic int frame_timeout(input int clk_hz, input int baud, input int frames);
        return frames * FRAME_BITS * (clk_hz / baud);
    endfunction

    localparam int TIMEOUT_CYCLES_DEF = frame_timeout(CLK_FREQ_HZ, BAUDRATE, 10);

endpackage

// File: rtl/uart_timeout_counter.sv
// Idle-clock counter: counts enabled clocks, pulses expire_o on the clock where the
// count would reach TIMEOUT_CYCLES and restarts; TIMEOUT_CYCLES=0 never expires.
module uart_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = ENABLED && en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i && ENABLED) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes little-endian into words, acknowledging each byte with a
// one-cycle clr_rx_flag; adds a read handshake, sticky overrun and a partial-word timeout.
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int UART_Nbit      = UART_NBIT_DEF,
    parameter int BYTES_PER_WORD = DATA_WIDTH / UART_Nbit,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [UART_Nbit-1:0]              rx_data,
    input  logic                              rx_flag,
    input  logic                              word_ack,
    output logic                              clr_rx_flag,
    output logic [DATA_WIDTH-1:0]             word_out,
    output logic                              word_valid,
    output logic                              overrun,
    output logic                              timeout_pulse,
    output logic [$clog2(BYTES_PER_WORD):0]   byte_count
);

    localparam int BCW = $clog2(BYTES_PER_WORD) + 1;

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] full_w;
    logic [BCW-1:0]        cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  tpulse_q;
    logic                  latch, expire, tmo_en;

    // Bytes are only taken in IDLE, so a late-dropping Rx_flag cannot be re-captured.
    assign latch  = (state_q == ST_IDLE) && rx_flag;
    assign tmo_en = (cnt_q != '0) && (state_q == ST_IDLE) && !rx_flag;

    uart_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .en_i    (tmo_en),
        .clr_i   (latch),
        .expire_o(expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (rx_flag) state_d = ST_CAPTURE;
            ST_CAPTURE:  state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!rx_flag) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        full_w  = shreg_q;
        if (word_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (latch) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (cnt_q == BCW'(k)) full_w[k*UART_Nbit +: UART_Nbit] = rx_data;
            end
            if (cnt_q == BCW'(BYTES_PER_WORD - 1)) begin
                cnt_d   = '0;
                shreg_d = '0;
                // A same-cycle ack frees the holding register, so completion wins.
                if (!valid_q || word_ack) begin
                    word_d  = full_w;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + BCW'(1);
                shreg_d = full_w;
            end
        end else if (expire) begin
            cnt_d   = '0;
            shreg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            tpulse_q <= expire;
        end
    end

    assign clr_rx_flag   = (state_q == ST_CAPTURE);
    assign word_out      = word_q;
    assign word_valid    = valid_q;
    assign overrun       = ovr_q;
    assign timeout_pulse = tpulse_q;
    assign byte_count    = cnt_q;

endmodule
